// File: rtl/onn_pkg.sv
// onn_pkg: shared ONN scheduler state encoding, default phase width and modular phase arithmetic.
package onn_pkg;

  localparam int ONN_PHASE_W = 4;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE    = 2'd0;
  localparam sched_state_t ST_ARM     = 2'd1;
  localparam sched_state_t ST_MEASURE = 2'd2;
  localparam sched_state_t ST_WRITE   = 2'd3;

  // Callers keep only their phase width of the result, which gives the modulo-2^W wrap.
  function automatic logic [31:0] phase_add(input logic [31:0] phi,
                                            input logic [31:0] diff,
                                            input logic        lead);
    return lead ? (phi - diff) : (phi + diff);
  endfunction

endpackage

// File: rtl/onn_phase_table.sv
// onn_phase_table: per-neuron phase register file with one accumulate-write port
// and a flattened read-out (neuron i at bits [i*PHASE_W +: PHASE_W]).
module onn_phase_table
  import onn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int PHASE_W   = ONN_PHASE_W,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [PHASE_W-1:0]             diff,
  input  logic                           lead,
  output logic [N_NEURONS*PHASE_W-1:0]   phase_vec
);

  logic [PHASE_W-1:0] entries [N_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        entries[i] <= '0;
      end
    end else if (we) begin
      entries[idx] <= PHASE_W'(phase_add(32'(entries[idx]), 32'(diff), lead));
    end
  end

  always_comb begin
    phase_vec = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      phase_vec[i*PHASE_W +: PHASE_W] = entries[i];
    end
  end

endmodule

// File: rtl/onn_phase_scheduler.sv
// onn_phase_scheduler: time-multiplexes one phase-difference measurement unit across the ONN neurons.
// Optional measurement timeout and sticky err flag are enabled with `define ONN_SCHED_TIMEOUT_EN.
module onn_phase_scheduler
  import onn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int PHASE_W   = ONN_PHASE_W
`ifdef ONN_SCHED_TIMEOUT_EN
  ,
  parameter int TMO_CYC   = 64
`endif
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               cont,
  input  logic                               soft_clr,
  input  logic                               ref_osc,
  input  logic                               meas_done,
  input  logic [PHASE_W-1:0]                 meas_diff,
  input  logic                               meas_lead,
  output logic [$clog2(N_NEURONS)-1:0]       sel,
  output logic                               meas_start,
  output logic [N_NEURONS*PHASE_W-1:0]       phase_vec,
  output logic                               busy,
  output logic                               sweep_done
`ifdef ONN_SCHED_TIMEOUT_EN
  ,
  output logic                               err
`endif
);

  localparam int SEL_W = $clog2(N_NEURONS);

  sched_state_t       state;
  logic               ref_q;
  logic               ref_rise;
  logic [PHASE_W-1:0] diff_q;
  logic               lead_q;
  logic               last_sel;
  logic [SEL_W-1:0]   next_sel;
  sched_state_t       adv_state;
  logic               table_we;
  logic               tmo_hit;

  assign ref_rise  = ref_osc & ~ref_q;
  assign busy      = (state != ST_IDLE);
  assign last_sel  = (sel == SEL_W'(N_NEURONS - 1));
  assign next_sel  = last_sel ? '0 : sel + SEL_W'(1);
  assign adv_state = (last_sel && !cont) ? ST_IDLE : ST_ARM;
  assign table_we  = (state == ST_WRITE) && !soft_clr;

`ifdef ONN_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_MEASURE) && !meas_done && (tmo_cnt == TMO_W'(TMO_CYC - 1));

  // Counter is held at zero outside MEASURE so every measurement gets a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state != ST_MEASURE || soft_clr) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (!soft_clr && state == ST_IDLE && start) begin
        err <= 1'b0;
      end else if (tmo_hit && !soft_clr) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // The reference edge detector runs in every state so ARM never sees a stale previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      ref_q      <= 1'b0;
      meas_start <= 1'b0;
      sweep_done <= 1'b0;
      diff_q     <= '0;
      lead_q     <= 1'b0;
    end else begin
      ref_q      <= ref_osc;
      meas_start <= 1'b0;
      sweep_done <= 1'b0;
      if (soft_clr) begin
        state <= ST_IDLE;
        sel   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_ARM;
              sel   <= '0;
            end
          end
          ST_ARM: begin
            if (ref_rise) begin
              meas_start <= 1'b1;
              state      <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (meas_done) begin
              diff_q <= meas_diff;
              lead_q <= meas_lead;
              state  <= ST_WRITE;
            end else if (tmo_hit) begin
              sel        <= next_sel;
              state      <= adv_state;
              sweep_done <= last_sel;
            end
          end
          ST_WRITE: begin
            sel        <= next_sel;
            state      <= adv_state;
            sweep_done <= last_sel;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  onn_phase_table #(
    .N_NEURONS (N_NEURONS),
    .PHASE_W   (PHASE_W),
    .IDX_W     (SEL_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (table_we),
    .idx       (sel),
    .diff      (diff_q),
    .lead      (lead_q),
    .phase_vec (phase_vec)
  );

endmodule

// File: tb/tb_onn_phase_scheduler.sv
// tb_onn_phase_scheduler: directed self-checking bench for onn_phase_scheduler (N=4, PHASE_W=4,
// reference period 16 cycles); the timeout section is compiled only with ONN_SCHED_TIMEOUT_EN.
module tb_onn_phase_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic        soft_clr;
  logic        ref_osc;
  logic        meas_done;
  logic [3:0]  meas_diff;
  logic        meas_lead;
  logic [1:0]  sel;
  logic        meas_start;
  logic [15:0] phase_vec;
  logic        busy;
  logic        sweep_done;
`ifdef ONN_SCHED_TIMEOUT_EN
  logic        err;
`endif

  int nCompared;
  int nMismatched;
  int cycleCnt;
  int riseCycle;
  logic [3:0] expTable [4];

  onn_phase_scheduler #(
    .N_NEURONS (4),
    .PHASE_W   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .soft_clr   (soft_clr),
    .ref_osc    (ref_osc),
    .meas_done  (meas_done),
    .meas_diff  (meas_diff),
    .meas_lead  (meas_lead),
    .sel        (sel),
    .meas_start (meas_start),
    .phase_vec  (phase_vec),
    .busy       (busy),
    .sweep_done (sweep_done)
`ifdef ONN_SCHED_TIMEOUT_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference oscillator: rises every 16 cycles, just after the clock edge it is tied to.
  initial begin
    ref_osc   = 1'b0;
    cycleCnt  = 0;
    riseCycle = -100;
    forever begin
      @(posedge clk);
      cycleCnt++;
      #1;
      if ((cycleCnt % 16) == 0) begin
        ref_osc   = 1'b1;
        riseCycle = cycleCnt;
      end else if ((cycleCnt % 16) == 8) begin
        ref_osc = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic startVal, input logic contVal);
    cont  = contVal;
    start = startVal;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitMeasStart(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (meas_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("measStartWait", 32'd0, 32'd1);
  endtask

  task automatic syncToRise();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cycleCnt == riseCycle) break;
    end
  endtask

  // Plays the measurement unit for one neuron and checks the table before and after the write.
  task automatic doMeasure(input int idx, input logic [3:0] diff, input logic lead,
                           input int latency, input logic pokeStart);
    logic ok;
    waitMeasStart(ok);
    if (!ok) return;
    checkOutput("measStartLag", 32'(cycleCnt - riseCycle), 32'd1);
    checkOutput("selAtMeasure", 32'(sel), 32'(idx));
    for (int k = 0; k < latency; k++) begin
      start = pokeStart;
      @(negedge clk);
    end
    start     = 1'b0;
    meas_diff = diff;
    meas_lead = lead;
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    checkOutput("entryBeforeWrite", 32'(phase_vec[idx*4 +: 4]), 32'(expTable[idx]));
    checkOutput("selAtWrite", 32'(sel), 32'(idx));
    @(negedge clk);
    expTable[idx] = lead ? 4'(expTable[idx] - diff) : 4'(expTable[idx] + diff);
    checkOutput("entryAfterWrite", 32'(phase_vec[idx*4 +: 4]), 32'(expTable[idx]));
  endtask

  initial begin
    logic ok;
    nCompared   = 0;
    nMismatched = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cont      = 1'b0;
    soft_clr  = 1'b0;
    meas_done = 1'b0;
    meas_diff = 4'd0;
    meas_lead = 1'b0;
    for (int i = 0; i < 4; i++) expTable[i] = 4'd0;

    repeat (3) @(negedge clk);
    checkOutput("rstSel", 32'(sel), 32'd0);
    checkOutput("rstMeasStart", 32'(meas_start), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstSweepDone", 32'(sweep_done), 32'd0);
    checkOutput("rstPhaseVec", 32'(phase_vec), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic sweep, diff=3 lag for every neuron");
    applyStimulus(1'b1, 1'b0);
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) doMeasure(i, 4'd3, 1'b0, i, 1'b0);
    checkOutput("sweepDonePulse", 32'(sweep_done), 32'd1);
    checkOutput("busyAfterSweep", 32'(busy), 32'd0);
    checkOutput("phaseVecSweep1", 32'(phase_vec), 32'h3333);
    @(negedge clk);
    checkOutput("sweepDoneOneCycle", 32'(sweep_done), 32'd0);

    $display("[TB] wrap-around sweeps");
    applyStimulus(1'b1, 1'b0);
    doMeasure(0, 4'd11, 1'b0, 1, 1'b0);
    doMeasure(1, 4'd1,  1'b1, 0, 1'b0);
    doMeasure(2, 4'd0,  1'b0, 0, 1'b0);
    doMeasure(3, 4'd0,  1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    doMeasure(0, 4'd3,  1'b0, 2, 1'b0);
    doMeasure(1, 4'd5,  1'b1, 0, 1'b0);
    doMeasure(2, 4'd0,  1'b0, 0, 1'b0);
    doMeasure(3, 4'd0,  1'b0, 0, 1'b0);
    checkOutput("phaseVecWrap", 32'(phase_vec), 32'h33D1);

    $display("[TB] ignored meas_done in IDLE and ARM, ignored start in MEASURE");
    meas_diff = 4'd7;
    meas_lead = 1'b0;
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    @(negedge clk);
    checkOutput("idleDoneIgnored", 32'(phase_vec), 32'h33D1);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    syncToRise();
    applyStimulus(1'b1, 1'b0);
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    @(negedge clk);
    checkOutput("armDoneIgnored", 32'(phase_vec), 32'h33D1);
    checkOutput("armStillArmed", 32'(meas_start), 32'd0);
    doMeasure(0, 4'd2, 1'b0, 3, 1'b1);
    doMeasure(1, 4'd1, 1'b0, 0, 1'b0);

    $display("[TB] soft_clr together with meas_done at sel=2");
    waitMeasStart(ok);
    checkOutput("selBeforeClr", 32'(sel), 32'd2);
    meas_diff = 4'd5;
    meas_lead = 1'b0;
    meas_done = 1'b1;
    soft_clr  = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    soft_clr  = 1'b0;
    checkOutput("clrBusy", 32'(busy), 32'd0);
    checkOutput("clrSel", 32'(sel), 32'd0);
    @(negedge clk);
    checkOutput("clrEntry2", 32'(phase_vec[11:8]), 32'd3);
    checkOutput("clrPhaseVec", 32'(phase_vec), 32'h33E3);

    $display("[TB] continuous mode and reset mid-measurement");
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) doMeasure(i, 4'd1, 1'b0, 0, 1'b0);
    checkOutput("contSweepDone", 32'(sweep_done), 32'd1);
    checkOutput("contBusy", 32'(busy), 32'd1);
    checkOutput("contSelWrap", 32'(sel), 32'd0);
    doMeasure(0, 4'd2, 1'b1, 0, 1'b0);
    cont = 1'b0;
    waitMeasStart(ok);
    checkOutput("contPhaseVec", 32'(phase_vec), 32'h44F2);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPhaseVec", 32'(phase_vec), 32'd0);
    checkOutput("asyncRstSel", 32'(sel), 32'd0);
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstMeasStart", 32'(meas_start), 32'd0);
    checkOutput("asyncRstSweepDone", 32'(sweep_done), 32'd0);
    for (int i = 0; i < 4; i++) expTable[i] = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef ONN_SCHED_TIMEOUT_EN
    $display("[TB] measurement timeout on neuron 1");
    applyStimulus(1'b1, 1'b0);
    doMeasure(0, 4'd1, 1'b0, 0, 1'b0);
    waitMeasStart(ok);
    begin
      int waited;
      waited = 0;
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (err) begin
          waited = k;
          break;
        end
      end
      checkOutput("tmoCycles", 32'(waited), 32'd64);
    end
    checkOutput("tmoEntry1", 32'(phase_vec[7:4]), 32'd0);
    checkOutput("tmoSelAdvance", 32'(sel), 32'd2);
    doMeasure(2, 4'd1, 1'b0, 0, 1'b0);
    doMeasure(3, 4'd1, 1'b0, 0, 1'b0);
    checkOutput("tmoErrSticky", 32'(err), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tmoErrCleared", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/onn_phase_scheduler.md
# onn_phase_scheduler

Time-multiplexes one shared phase-difference measurement unit across `N_NEURONS` oscillator neurons of the ONN. The scheduler:
- selects one neuron at a time;
- aligns each measurement window to a rising edge of the reference oscillator;
- collects the signed phase difference and accumulates it into an internal per-neuron phase table (modulo 2^PHASE_W).

It sits between the neuron array and the single measurement datapath, and drives the phase vector consumed by the neuron control blocks.

## Interface
Parameters:
- `N_NEURONS`, 4, number of neurons served (≥2)
- `PHASE_W`, 4, phase word width; phase arithmetic wraps modulo 2^PHASE_W
- `TMO_CYC`, 64, measurement timeout in clk cycles (used only with `ONN_SCHED_TIMEOUT_EN`)

Ports:
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: begin a sweep; sampled only in IDLE
- `cont` in 1: at end of sweep, restart at neuron 0 instead of idling
- `soft_clr` in 1: synchronous abort to IDLE; phase table kept
- `ref_osc` in 1: reference oscillator, synchronous to clk
- `meas_done` in 1: one-cycle pulse from the measurement unit, result valid
- `meas_diff` in PHASE_W: unsigned phase-difference magnitude
- `meas_lead` in 1: 1 = selected neuron leads the reference (subtract), 0 = lags (add)
- `sel` out clog2(N_NEURONS): index of the neuron routed to the measurement unit
- `meas_start` out 1: one-cycle pulse starting a measurement
- `phase_vec` out N_NEURONS*PHASE_W: phase table; neuron i occupies bits [i*PHASE_W +: PHASE_W]
- `busy` out 1: high in any state other than IDLE
- `sweep_done` out 1: one-cycle pulse after the last neuron's write
- `err` out 1: sticky timeout flag, cleared by `start` (only with `ONN_SCHED_TIMEOUT_EN`)

## Operation
- States: IDLE, ARM, MEASURE, WRITE.
- IDLE:
  - `start`=1 → ARM with `sel`=0.
  - `meas_done` is ignored.
- ARM:
  - Register `ref_osc` and detect a rising edge (current 1, previous 0).
  - On the edge: pulse `meas_start` → MEASURE.
  - `meas_done` in ARM is ignored.
- MEASURE:
  - On `meas_done`, latch `meas_diff`/`meas_lead` → WRITE.
- WRITE, one cycle:
  - `table[sel] <= meas_lead ? table[sel] - meas_diff : table[sel] + meas_diff`, truncated to PHASE_W.
  - Then: if `sel`≠N_NEURONS-1, do `sel`+1 → ARM.
  - Otherwise pulse `sweep_done`, then go to ARM with `sel`=0 if `cont`=1, else to IDLE.
- `soft_clr` has the highest priority:
  - From any state, next state is IDLE and `sel`=0.
  - A write pending in the same cycle is suppressed.
  - The table is untouched.
- `sel` stays constant from ARM entry through the WRITE cycle.
- Wrap examples (PHASE_W=4): 14+3=1; 2-5=13.

## Timing
- Reset values:
  - state IDLE, `sel`=0
  - `meas_start`=0, `busy`=0, `sweep_done`=0, `err`=0
  - all phase table entries 0; the registered edge-detect flop = 0
- `meas_start` is asserted in the cycle after the registered edge is seen, so it lags the `ref_osc` rise by 1 cycle.
- `meas_done` → table updated and visible on `phase_vec` 2 cycles later (latch cycle + WRITE).
- Per-neuron cost = wait for ref edge + measurement latency + 2 cycles.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle state returns to IDLE.
- `sweep_done` and the transition out of WRITE occur on the same edge.
- `meas_done` arriving on the same edge `meas_start` is issued is not accepted; only MEASURE-state pulses count.
- `start` while busy: ignored.
- Async reset mid-sweep: immediate return to reset values, including the table.

## Configuration
- `ONN_SCHED_TIMEOUT_EN` defined:
  - A counter runs in MEASURE.
  - After `TMO_CYC` cycles without `meas_done`: set `err`, skip the write (no table change), and advance as if WRITE completed.
- Macro undefined:
  - No counter and no `err` port.
  - MEASURE waits indefinitely.

## Structure
- Shared package `onn_pkg`:
  - the state enum (IDLE/ARM/MEASURE/WRITE)
  - the default `PHASE_W`
  - a `phase_add(phi, diff, lead)` modular-arithmetic function, reused by the neuron control blocks
- One sub-module `onn_phase_table`:
  - N×PHASE_W register file with asynchronous reset, a single write port (idx, diff, lead, we) and flattened read-out `phase_vec`.

## Test plan
- Reset then `start`, N=4, `ref_osc` period 16, model returns diff=3 lag for each neuron → four `meas_start` pulses each 1 cycle after a ref rise; `phase_vec` entries all 3; one `sweep_done`; `busy` low afterwards.
- Wrap: neuron 0 preloaded to 14 by prior sweeps, diff=3 lag → 1; neuron 1 at 2, diff=5 lead → 13.
- `meas_done` pulsed in IDLE and in ARM → ignored, no table change; `start` during MEASURE → ignored.
- `soft_clr` asserted in the same cycle as `meas_done` for `sel`=2 → IDLE next cycle, entry 2 unchanged, `sel`=0.
- `cont`=1 → after `sel`=3 the next state is ARM with `sel`=0; `rst_n` low mid-MEASURE → all outputs and the table read 0 immediately.
- With `ONN_SCHED_TIMEOUT_EN`, TMO_CYC=64, no `meas_done` for neuron 1 → `err`=1 at cycle 64 of MEASURE, entry 1 unchanged, sweep continues to neuron 2; the next `start` clears `err`.
